// File: rtl/aes_decrypt_core.sv
// Iterative AES-128 inverse cipher: forward key expansion to rk10 once per key,
// then one block per 11 cycles with round keys regenerated backwards on the fly.
module aes_decrypt_core (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [127:0] main_key,
  input  logic         data_valid,
  output logic         data_ready,
  input  logic [127:0] data_in,
  output logic         data_out_valid,
  output logic [127:0] data_out
);

  typedef enum logic [1:0] {KEY_WAIT, KEY_EXP, IDLE, DEC} state_t;

  state_t       r_state, w_next;
  logic [3:0]   r_round;
  logic [127:0] r_key, r_rk10, r_blk, r_dout;
  logic         r_dout_valid;
  logic [127:0] w_key_fwd, w_key_inv, w_sr_sb, w_round_mid;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0), so both S-boxes stay table-free.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] a2, a3, a12, a15, a240;
    a2   = gf_mul(a, a);
    a3   = gf_mul(a2, a);
    a12  = gf_mul(gf_mul(a3, a3), gf_mul(a3, a3));
    a15  = gf_mul(a12, a3);
    a240 = a15;
    for (int i = 0; i < 4; i++) a240 = gf_mul(a240, a240);
    return gf_mul(gf_mul(a240, a12), a2);
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] a, input int unsigned n);
    return (a << n) | (a >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return gf_inv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
    logic [31:0] rw, o;
    rw = {w[23:0], w[31:24]};
    for (int i = 0; i < 4; i++) o[8*i +: 8] = sbox(rw[8*i +: 8]);
    return o;
  endfunction

  function automatic logic [127:0] key_fwd(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w0 = k[127:96] ^ sub_rot_word(k[31:0]) ^ {rc, 24'h0};
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0]  ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [127:0] key_inv(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w3 = k[31:0]  ^ k[63:32];
    w2 = k[63:32] ^ k[95:64];
    w1 = k[95:64] ^ k[127:96];
    w0 = k[127:96] ^ sub_rot_word(w3) ^ {rc, 24'h0};
    return {w0, w1, w2, w3};
  endfunction

  // Byte r+4c sits at bits [127-8*(r+4c) -: 8]; row r rotates right by r columns.
  function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
    logic [127:0] o;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127-8*(r+4*c) -: 8] = inv_sbox(s[127-8*(r+4*((c-r+4)%4)) -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gf_mul(a0,8'h0e)^gf_mul(a1,8'h0b)^gf_mul(a2,8'h0d)^gf_mul(a3,8'h09);
      o[119-32*c -: 8] = gf_mul(a0,8'h09)^gf_mul(a1,8'h0e)^gf_mul(a2,8'h0b)^gf_mul(a3,8'h0d);
      o[111-32*c -: 8] = gf_mul(a0,8'h0d)^gf_mul(a1,8'h09)^gf_mul(a2,8'h0e)^gf_mul(a3,8'h0b);
      o[103-32*c -: 8] = gf_mul(a0,8'h0b)^gf_mul(a1,8'h0d)^gf_mul(a2,8'h09)^gf_mul(a3,8'h0e);
    end
    return o;
  endfunction

  // One inverse key step serves both the IDLE accept (rk10 -> rk9) and each DEC round.
  always_comb begin
    w_key_fwd   = key_fwd(r_key, rcon(r_round));
    w_key_inv   = (r_state == IDLE) ? key_inv(r_rk10, rcon(4'd10))
                                    : key_inv(r_key, rcon(r_round));
    w_sr_sb     = inv_shift_sub(r_blk);
    w_round_mid = inv_mix_columns(w_sr_sb ^ r_key);
  end

  // NOTE: every output of this block is given a default first so no latch is inferred.
  always_comb begin
    w_next     = r_state;
    key_ready  = 1'b0;
    data_ready = 1'b0;
    case (r_state)
      KEY_WAIT: begin
        key_ready = 1'b1;
        if (key_valid) w_next = KEY_EXP;
      end
      KEY_EXP: if (r_round == 4'd10) w_next = IDLE;
      IDLE: begin
        key_ready  = 1'b1;
        data_ready = 1'b1;
        if (key_valid)       w_next = KEY_EXP;
        else if (data_valid) w_next = DEC;
      end
      DEC: if (r_round == 4'd0) w_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) r_state <= KEY_WAIT;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_round      <= 4'd0;
      r_key        <= '0;
      r_rk10       <= '0;
      r_blk        <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
    end else begin
      r_dout_valid <= 1'b0;
      case (r_state)
        KEY_WAIT: if (key_valid) begin
          r_key   <= main_key;
          r_round <= 4'd1;
        end
        KEY_EXP: begin
          r_key   <= w_key_fwd;
          r_round <= r_round + 4'd1;
          if (r_round == 4'd10) r_rk10 <= w_key_fwd;
        end
        IDLE: if (key_valid) begin
          r_key   <= main_key;
          r_round <= 4'd1;
        end else if (data_valid) begin
          r_blk   <= data_in ^ r_rk10;
          r_key   <= w_key_inv;
          r_round <= 4'd9;
        end
        DEC: if (r_round != 4'd0) begin
          r_blk   <= w_round_mid;
          r_key   <= w_key_inv;
          r_round <= r_round - 4'd1;
        end else begin
          r_dout       <= w_sr_sb ^ r_key;
          r_dout_valid <= 1'b1;
        end
      endcase
    end
  end

  assign data_out       = r_dout;
  assign data_out_valid = r_dout_valid;

endmodule

// File: tb/tb_aes_decrypt_core.sv
// Scoreboard bench for aes_decrypt_core: FIPS-197 vectors, back-to-back blocks,
// rekey priority, mid-block reset and ignored-input handling.
module tb_aes_decrypt_core;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

  typedef struct {
    logic [127:0] pt;
    int           cyc;
    bit           differ;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         key_valid, key_ready, data_valid, data_ready, data_out_valid;
  logic [127:0] main_key, data_in, data_out;

  exp_t         sb[$];
  logic [127:0] exp_pt;
  bit           exp_differ;
  int           cyc = 0;
  int           total = 0;
  int           bad = 0;

  aes_decrypt_core dut (
    .clk(clk), .rst(rst),
    .key_valid(key_valid), .key_ready(key_ready), .main_key(main_key),
    .data_valid(data_valid), .data_ready(data_ready), .data_in(data_in),
    .data_out_valid(data_out_valid), .data_out(data_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // A block offered while ready is taken on the next edge; plaintext is due 10 edges later.
  always @(negedge clk) begin
    if (!rst && data_valid && data_ready && !key_valid)
      sb.push_back('{pt: exp_pt, cyc: cyc + 11, differ: exp_differ});
  end

  always @(negedge clk) begin
    exp_t e;
    if (data_out_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_strobe", 1, 0);
      end else begin
        e = sb.pop_front();
        if (e.differ) check("pt_differs", (data_out != e.pt) ? 1 : 0, 1);
        else          check("plaintext", data_out, e.pt);
        check("strobe_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic wait_ready(input bit is_key, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 40 && !ok; t++) begin
      @(negedge clk);
      if (is_key ? key_ready : data_ready) ok = 1'b1;
    end
    if (!ok) check(is_key ? "key_ready_timeout" : "data_ready_timeout", 0, 1);
  endtask

  task automatic load_key(input logic [127:0] k, input bit with_data, input bit pulse_dv);
    bit ok;
    @(posedge clk); #1;
    main_key  = k;
    key_valid = 1'b1;
    if (with_data) begin
      data_in    = C1_CT;
      exp_pt     = C1_PT;
      data_valid = 1'b1;
    end
    wait_ready(1'b1, ok);
    if (ok) begin
      @(posedge clk); #1;
      key_valid  = 1'b0;
      data_valid = 1'b0;
      for (int i = 1; i <= 11; i++) begin
        @(negedge clk);
        check("key_ready_exp", key_ready, i == 11);
        check("data_ready_exp", data_ready, i == 11);
        if (pulse_dv && i == 4) begin
          data_in    = C1_CT;
          data_valid = 1'b1;
        end
        if (pulse_dv && i == 5) data_valid = 1'b0;
      end
    end
    key_valid  = 1'b0;
    data_valid = 1'b0;
  endtask

  task automatic send(input logic [127:0] ct, input logic [127:0] pt, input int n,
                      input bit differ, input bit kv_pulse);
    bit ok;
    @(posedge clk); #1;
    exp_pt     = pt;
    exp_differ = differ;
    data_in    = ct;
    data_valid = 1'b1;
    wait_ready(1'b0, ok);
    if (ok) begin
      for (int k = 0; k < n; k++) begin
        @(posedge clk); #1;
        if (k == n - 1) data_valid = 1'b0;
        for (int i = 1; i <= 11; i++) begin
          @(negedge clk);
          check("data_ready_dec", data_ready, i == 11);
          check("key_ready_dec", key_ready, i == 11);
          if (kv_pulse && k == 0 && i == 3) begin
            main_key  = ~ct;
            key_valid = 1'b1;
          end
          if (kv_pulse && k == 0 && i == 4) key_valid = 1'b0;
        end
      end
    end
    data_valid = 1'b0;
    exp_differ = 1'b0;
  endtask

  task automatic reset_mid_block();
    bit ok;
    @(posedge clk); #1;
    exp_pt     = C1_PT;
    exp_differ = 1'b0;
    data_in    = C1_CT;
    data_valid = 1'b1;
    wait_ready(1'b0, ok);
    @(posedge clk); #1;
    data_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    check("rst_dout_valid", data_out_valid, 0);
    check("rst_dout", data_out, 0);
    check("rst_key_ready", key_ready, 1);
    check("rst_data_ready", data_ready, 0);
    repeat (20) begin
      @(negedge clk);
      check("rst_no_strobe", data_out_valid, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst        = 1'b1;
    key_valid  = 1'b0;
    data_valid = 1'b0;
    main_key   = '0;
    data_in    = '0;
    exp_pt     = '0;
    exp_differ = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_key_ready", key_ready, 1);
    check("reset_data_ready", data_ready, 0);
    check("reset_dout_valid", data_out_valid, 0);
    check("reset_dout", data_out, 0);

    // C.1 vector, with stray data_valid in KEY_EXP and stray key_valid in DEC
    load_key(C1_KEY, 1'b0, 1'b1);
    send(C1_CT, C1_PT, 1, 1'b0, 1'b1);

    // App. B vector, then key retention without re-expansion
    load_key(B_KEY, 1'b0, 1'b0);
    send(B_CT, B_PT, 1, 1'b0, 1'b0);
    send(C1_CT, C1_PT, 1, 1'b1, 1'b0);
    send(B_CT, B_PT, 1, 1'b0, 1'b0);

    // Back-to-back blocks under one key
    load_key(C1_KEY, 1'b0, 1'b0);
    send(C1_CT, C1_PT, 3, 1'b0, 1'b0);

    // Key and data together in IDLE: key wins, data is dropped
    load_key(B_KEY, 1'b1, 1'b0);
    send(B_CT, B_PT, 1, 1'b0, 1'b0);

    reset_mid_block();
    load_key(C1_KEY, 1'b0, 1'b0);
    send(C1_CT, C1_PT, 1, 1'b0, 1'b0);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes_decrypt_core.md
Name: aes_decrypt_core

Overview:
- Iterative AES-128 inverse cipher (FIPS-197 Sec. 5.3), the decryption-side counterpart of the pipelined encryption core.
- Takes one 128-bit key and expands it forward once to round key 10.
- Decrypts one 128-bit ciphertext block at a time, regenerating round keys 9..0 backwards on the fly.
- Sits at the receive end of the link, after demodulation, and hands plaintext to the baseband data path.

Parameters:
None. The block is fixed to AES-128: 10 rounds, 128-bit key, 128-bit block.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
key_valid  input  1  main_key is valid this cycle
key_ready  output  1  block can accept a new key
main_key  input  128  cipher key, FIPS byte 0 in bits [127:120]
data_valid  input  1  data_in (ciphertext) is valid this cycle
data_ready  output  1  block can accept a ciphertext block
data_in  input  128  ciphertext, byte 0 in bits [127:120]
data_out_valid  output  1  one-cycle strobe; data_out holds plaintext
data_out  output  128  plaintext, byte 0 in bits [127:120]

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous and active-high.
- Reset values: key_ready=1, data_ready=0, data_out_valid=0, data_out=0, FSM=KEY_WAIT, key-loaded flag cleared.
- Reset mid-operation aborts any expansion or decryption, with no output strobe.
- FSM states: KEY_WAIT, KEY_EXP, IDLE, DEC.
- KEY_WAIT:
  - key_ready=1, data_ready=0.
  - On key_valid at edge K0: store main_key as rk0, load working key, set round counter=1, go to KEY_EXP.
- KEY_EXP:
  - key_ready=0, data_ready=0.
  - Each edge K1..K10 computes rk[r] from rk[r-1]: w0'=w0^SubWord(RotWord(w3))^Rcon[r], then wi'=wi^w(i-1)' for i=1..3.
  - Rcon = 01,02,04,08,10,20,40,80,1B,36.
  - After K10, hold rk10 and go to IDLE. Ten cycles total; key_valid is ignored throughout.
- IDLE:
  - key_ready=1, data_ready=1.
  - data_valid&&!key_valid at edge E0: state=data_in^rk10, working key=InvExpand(rk10)=rk9, round=9, go to DEC.
  - key_valid (alone or together with data_valid): rekey exactly as in KEY_WAIT. Key has priority; the data block is NOT accepted and must be re-presented.
- DEC:
  - key_ready=0, data_ready=0; data_valid and key_valid are ignored.
  - Edges E1..E9 (round 9 down to 1): state=InvMixColumns(InvSubBytes(InvShiftRows(state))^rk_r).
  - Each edge also steps the key backwards: wi=wi'^w(i-1)' for i=3..1, w0=w0'^SubWord(RotWord(w3))^Rcon[r], using the newly computed w3.
  - Edge E10 (final round): data_out=InvSubBytes(InvShiftRows(state))^rk0, data_out_valid=1 for one cycle, go to IDLE.
- Latency: data_out_valid is high in the cycle after E10, i.e. 10 clock edges after the accepting edge.
- Throughput: data_ready is high in the same cycle as data_out_valid, so back-to-back blocks run at one block per 11 cycles.
- Key storage: rk10 is kept in a dedicated register, unchanged by DEC. Decryptions under the same key need no re-expansion.
- Outputs: data_out holds its value until the next E10. data_out_valid is 0 in every other cycle.
- S-box: forward S-box (key schedule) and inverse S-box (state) are combinational byte lookups. No memory macros.
- GF(2^8) arithmetic: xtime reduction polynomial 0x11B. InvMixColumns coefficients 0e,0b,0d,09.
- Byte order: byte 0 is the most significant byte. Column c holds bytes 4c..4c+3.
- Protocol errors: data_valid in KEY_WAIT/KEY_EXP/DEC is dropped silently, with no state change.

Test Plan:
- FIPS-197 App. C.1: key 000102030405060708090a0b0c0d0e0f, ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a -> data_out 00112233445566778899aabbccddeeff, valid exactly 10 edges after acceptance; key_ready/data_ready rise 10 edges after key acceptance.
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, ciphertext 3925841d02dc09fbdc118597196a0b32 -> 3243f6a8885a308d313198a2e0370734. Then present C.1 ciphertext under this key without a rekey -> result differs from C.1 plaintext, proving key retention.
- Back-to-back: hold data_valid high with C.1 ciphertext for 3 blocks -> 3 strobes spaced 11 cycles apart, all 00112233445566778899aabbccddeeff; data_ready low during each DEC.
- Rekey priority: in IDLE assert key_valid and data_valid together -> no data accepted, data_out_valid stays 0, key_ready=0 for 10 cycles. Then B ciphertext with the B key -> B plaintext.
- Reset mid-decryption: assert rst at E5 -> next cycle data_out_valid=0, data_out=0, key_ready=1, data_ready=0, and no strobe for 20 cycles. Reload the C.1 key and ciphertext -> correct plaintext.
- Ignored inputs: pulse data_valid during KEY_EXP and key_valid during DEC -> no acceptance and no change in result or timing.
